// File: rtl/aes_req_arbiter_if.sv
// Request/response bus between NUM_REQ requesters and the shared AES arbiter.
// The master side is the requester system and the slave side is the arbiter.
interface aes_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*128-1:0] req_data;
    logic [NUM_REQ*128-1:0] req_key;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [127:0]           resp_data;
    logic [ID_W-1:0]        resp_id;
    logic                   resp_err;

    modport master (
        output req_valid, req_data, req_key, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id, resp_err
    );

    modport slave (
        input  req_valid, req_data, req_key, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id, resp_err
    );
endinterface

// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter sharing one AES_top core among NUM_REQ requesters:
// grants, holds core_en for EN_HOLD cycles, then returns the result or a timeout.
module aes_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int EN_HOLD = 51,
    parameter int TIMEOUT = 128
) (
    input  logic                AES_clk,
    input  logic                AES_rst,
    aes_req_arbiter_if.slave    bus,
    output logic                busy,
    output logic                core_en,
    output logic [127:0]        core_data_in,
    output logic [127:0]        core_key_in,
    input  logic [127:0]        core_data_out,
    input  logic                core_data_out_valid
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ID_W-1:0]   ptr_reg;
    logic [127:0]      data_in_reg, key_in_reg, resp_data_reg;
    logic [ID_W-1:0]   resp_id_reg;
    logic              resp_err_reg;

    logic [127:0]      data_arr [NUM_REQ];
    logic [127:0]      key_arr  [NUM_REQ];
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W:0]     sum;
    logic              accept;
    logic              at_hold_end, at_timeout;

    assign accept      = (state_reg == IDLE) && grant_found && !AES_rst;
    assign at_hold_end = (cnt_reg == CNT_W'(EN_HOLD));
    assign at_timeout  = (cnt_reg == CNT_W'(TIMEOUT));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign data_arr[gi]      = bus.req_data[128*gi +: 128];
            assign key_arr[gi]       = bus.req_key[128*gi +: 128];
            assign bus.req_ready[gi] = accept && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_reg} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ))
                sum = sum - (ID_W+1)'(NUM_REQ);
            if (!grant_found && bus.req_valid[sum[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = sum[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next     = state_reg;
        core_en        = 1'b0;
        busy           = 1'b1;
        bus.resp_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (accept)
                    state_next = LOAD;
            end
            LOAD: begin
                core_en = 1'b1;
                if (core_data_out_valid)
                    state_next = RESP;
                else if (at_hold_end)
                    state_next = WAIT;
            end
            WAIT: begin
                if (core_data_out_valid || at_timeout)
                    state_next = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A core result takes priority over a timeout landing in the same cycle.
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            cnt_reg       <= '0;
            ptr_reg       <= '0;
            data_in_reg   <= '0;
            key_in_reg    <= '0;
            resp_data_reg <= '0;
            resp_id_reg   <= '0;
            resp_err_reg  <= 1'b0;
        end else if (accept) begin
            data_in_reg <= data_arr[grant_idx];
            key_in_reg  <= key_arr[grant_idx];
            resp_id_reg <= grant_idx;
            ptr_reg     <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
            cnt_reg     <= CNT_W'(1);
        end else if (state_reg == LOAD || state_reg == WAIT) begin
            if (core_data_out_valid) begin
                resp_data_reg <= core_data_out;
                resp_err_reg  <= 1'b0;
            end else if (at_timeout) begin
                resp_data_reg <= '0;
                resp_err_reg  <= 1'b1;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign core_data_in  = data_in_reg;
    assign core_key_in   = key_in_reg;
    assign bus.resp_data = resp_data_reg;
    assign bus.resp_id   = resp_id_reg;
    assign bus.resp_err  = resp_err_reg;
endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter with a behavioural core stub whose
// result is data^key, released on a cycle chosen by each test.
module tb_aes_req_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic         AES_clk = 1'b0;
    logic         AES_rst = 1'b1;
    logic         busy, core_en, core_data_out_valid;
    logic [127:0] core_data_in, core_key_in, core_data_out, stub_noise;
    logic [127:0] pt [NUM_REQ];
    logic [127:0] ky [NUM_REQ];

    int n_vec = 0;
    int n_bad = 0;

    aes_req_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    aes_req_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .EN_HOLD(51), .TIMEOUT(128)) dut (
        .AES_clk             (AES_clk),
        .AES_rst             (AES_rst),
        .bus                 (bus),
        .busy                (busy),
        .core_en             (core_en),
        .core_data_in        (core_data_in),
        .core_key_in         (core_key_in),
        .core_data_out       (core_data_out),
        .core_data_out_valid (core_data_out_valid)
    );

    always #5 AES_clk = ~AES_clk;

    assign core_data_out = core_data_in ^ core_key_in ^ stub_noise;

    always_comb begin
        bus.req_data = '0;
        bus.req_key  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_data[128*i +: 128] = pt[i];
            bus.req_key[128*i +: 128]  = ky[i];
        end
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge AES_clk);
        #1;
    endtask

    task automatic do_reset();
        AES_rst = 1'b1;
        step();
        step();
        AES_rst = 1'b0;
    endtask

    // Checks the grant in the current IDLE cycle, then moves to LOAD cycle 1.
    task automatic do_grant(input int exp_id);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        oh[exp_id] = 1'b1;
        #1;
        check_val("grant_ready", 128'(bus.req_ready), 128'(oh));
        check_val("grant_idle", 128'(busy), 128'(0));
        step();
    endtask

    // Runs from LOAD cycle 1 until resp_valid is seen; valid_at < 0 never answers.
    task automatic serve(input int valid_at, input int limit,
                         output int resp_t, output int en_cnt, output logic ready_seen);
        resp_t     = -1;
        en_cnt     = 0;
        ready_seen = 1'b0;
        for (int t = 1; t <= limit; t++) begin
            core_data_out_valid = (t == valid_at);
            #1;
            if (bus.resp_valid) begin
                resp_t = t;
                break;
            end
            if (core_en) en_cnt++;
            if (bus.req_ready != '0) ready_seen = 1'b1;
            step();
        end
        core_data_out_valid = 1'b0;
        check_val("resp_within_bound", 128'(resp_t >= 0), 128'(1));
        $display("op: resp id=%0d err=%0d data=%h at cycle %0d core_en=%0d",
                 bus.resp_id, bus.resp_err, bus.resp_data, resp_t, en_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rt, en, e, bad;
        logic rs;
        bus.req_valid       = '0;
        bus.resp_ready      = 1'b0;
        core_data_out_valid = 1'b0;
        stub_noise          = '0;
        pt[0] = 128'h000000fd_00000000_00000000_00000000;
        ky[0] = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
        pt[1] = 128'h00112233_44556677_8899aabb_ccddeeff;
        ky[1] = 128'h00010203_04050607_08090a0b_0c0d0e0f;
        pt[2] = 128'h3243f6a8_885a308d_313198a2_e0370734;
        ky[2] = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        pt[3] = 128'hffffffff_00000000_ffffffff_00000000;
        ky[3] = 128'h0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f;

        do_reset();
        #1;
        check_val("rst_busy", 128'(busy), 128'(0));
        check_val("rst_core_en", 128'(core_en), 128'(0));
        check_val("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
        check_val("rst_resp_data", bus.resp_data, 128'(0));
        check_val("rst_core_data_in", core_data_in, 128'(0));
        check_val("rst_req_ready", 128'(bus.req_ready), 128'(0));

        // Single request, result 60 cycles after core_en rises
        bus.req_valid = 4'b0001;
        do_grant(0);
        serve(61, 200, rt, en, rs);
        check_val("t1_resp_cycle", 128'(rt), 128'(62));
        check_val("t1_en_cycles", 128'(en), 128'(51));
        check_val("t1_resp_data", bus.resp_data, 128'haa2bdbbd_bff6a5e8_caa9ba3e_bc1e2acc);
        check_val("t1_resp_id", 128'(bus.resp_id), 128'(0));
        check_val("t1_resp_err", 128'(bus.resp_err), 128'(0));
        check_val("t1_no_ready_busy", 128'(rs), 128'(0));
        bus.resp_ready = 1'b1;
        bus.req_valid  = '0;
        step();
        bus.resp_ready = 1'b0;
        #1;
        check_val("t1_idle_busy", 128'(busy), 128'(0));
        check_val("t1_idle_resp_valid", 128'(bus.resp_valid), 128'(0));

        // Round-robin with every requester asserting
        do_reset();
        bus.req_valid  = 4'b1111;
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            e = k % NUM_REQ;
            do_grant(e);
            serve(3, 50, rt, en, rs);
            check_val("rr_resp_cycle", 128'(rt), 128'(4));
            check_val("rr_resp_id", 128'(bus.resp_id), 128'(e));
            check_val("rr_resp_data", bus.resp_data, pt[e] ^ ky[e]);
            check_val("rr_no_ready_busy", 128'(rs), 128'(0));
            step();
        end

        // Timeout: stub never answers
        bus.req_valid = 4'b0100;
        do_grant(2);
        bus.req_valid = '0;
        serve(-1, 300, rt, en, rs);
        check_val("to_resp_cycle", 128'(rt), 128'(129));
        check_val("to_en_cycles", 128'(en), 128'(51));
        check_val("to_resp_err", 128'(bus.resp_err), 128'(1));
        check_val("to_resp_data", bus.resp_data, 128'(0));
        check_val("to_resp_id", 128'(bus.resp_id), 128'(2));
        bus.req_valid = 4'b0001;
        step();
        do_grant(0);
        serve(10, 50, rt, en, rs);
        check_val("to_after_cycle", 128'(rt), 128'(11));
        check_val("to_after_err", 128'(bus.resp_err), 128'(0));
        step();

        // Backpressure: response must hold for 20 cycles
        bus.resp_ready = 1'b0;
        bus.req_valid  = 4'b1111;
        do_grant(1);
        serve(20, 50, rt, en, rs);
        check_val("bp_resp_cycle", 128'(rt), 128'(21));
        check_val("bp_resp_id", 128'(bus.resp_id), 128'(1));
        bad = 0;
        repeat (20) begin
            step();
            #1;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== (pt[1] ^ ky[1]) ||
                bus.resp_id !== 2'd1 || bus.resp_err !== 1'b0 ||
                busy !== 1'b1 || bus.req_ready !== 4'b0000)
                bad = 1;
        end
        check_val("bp_stable", 128'(bad), 128'(0));
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        #1;
        check_val("bp_released", 128'(bus.resp_valid), 128'(0));
        do_grant(2);

        // Reset in LOAD cycle 10
        repeat (9) step();
        #1;
        check_val("mr_pre_core_en", 128'(core_en), 128'(1));
        AES_rst = 1'b1;
        #1;
        check_val("mr_core_en", 128'(core_en), 128'(0));
        check_val("mr_busy", 128'(busy), 128'(0));
        check_val("mr_resp_valid", 128'(bus.resp_valid), 128'(0));
        check_val("mr_req_ready", 128'(bus.req_ready), 128'(0));
        step();
        AES_rst = 1'b0;
        do_grant(0);

        // Early result in LOAD, then a stray core valid during RESP
        bus.req_valid = '0;
        serve(5, 50, rt, en, rs);
        check_val("er_resp_cycle", 128'(rt), 128'(6));
        check_val("er_en_cycles", 128'(en), 128'(5));
        check_val("er_core_en_off", 128'(core_en), 128'(0));
        check_val("er_resp_data", bus.resp_data, pt[0] ^ ky[0]);
        stub_noise          = '1;
        core_data_out_valid = 1'b1;
        step();
        core_data_out_valid = 1'b0;
        stub_noise          = '0;
        #1;
        check_val("er_stray_data", bus.resp_data, pt[0] ^ ky[0]);
        check_val("er_stray_valid", 128'(bus.resp_valid), 128'(1));
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        #1;
        check_val("er_done_busy", 128'(busy), 128'(0));
        core_data_out_valid = 1'b1;
        step();
        core_data_out_valid = 1'b0;
        #1;
        check_val("idle_ignore_busy", 128'(busy), 128'(0));
        check_val("idle_ignore_resp", 128'(bus.resp_valid), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
